// File: rtl/video_fetch_ctrl_pkg.sv
// Shared definitions for the pixel-buffer refill controller: slice width,
// default geometry and the fetch sequencer state encoding.
package video_fetch_ctrl_pkg;

  localparam int SLICE_WIDTH     = 8;
  localparam int DEF_BSIZE       = 4;
  localparam int DEF_ADDR_W      = 15;
  localparam int DEF_FRAME_WORDS = 19200;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    STAGED  = 3'd2,
    LOAD    = 3'd3,
    WAIT_WM = 3'd4
  } fetch_state_e;

  // An empty buffer is expected while a staged word is about to be loaded.
  function automatic logic underrun_exempt(input fetch_state_e st);
    return (st == STAGED) || (st == LOAD);
  endfunction

endpackage

// File: rtl/video_fetch_ctrl_fetch_addr_ctr.sv
// Frame-memory word address counter: synchronous clear, increment enable,
// wraps to zero after the last word of the frame.
module fetch_addr_ctr #(
  parameter int ADDR_W      = 15,
  parameter int FRAME_WORDS = 19200
) (
  input  logic              clk25MHz,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  logic [ADDR_W-1:0] addr_r;

  // Address register; clear wins over increment.
  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if (clr) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if (inc) begin
      if (addr_r == LAST_ADDR) begin
        addr_r <= {ADDR_W{1'b0}};
      end else begin
        addr_r <= addr_r + ADDR_W'(1);
      end
    end else begin
      addr_r <= addr_r;
    end
  end

  assign addr = addr_r;

endmodule

// File: rtl/video_fetch_ctrl.sv
// Refill sequencer for the pixel FIFO: fetches one word ahead from frame
// memory, loads it when the buffer runs empty, and flags display underruns.
module video_fetch_ctrl
  import video_fetch_ctrl_pkg::*;
#(
  parameter int BSIZE       = DEF_BSIZE,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                         clk25MHz,
  input  logic                         reset,
  input  logic                         active,
  input  logic                         frame_start,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ack,
  input  logic [BSIZE*SLICE_WIDTH-1:0] mem_data,
  output logic [BSIZE*SLICE_WIDTH-1:0] buf_data,
  output logic                         buf_load,
  output logic                         buf_en,
  input  logic                         buf_watermark,
  input  logic                         buf_empty,
  output logic                         underrun
);

  localparam int DATA_W = BSIZE * SLICE_WIDTH;

  fetch_state_e      state_r;
  fetch_state_e      state_next_s;
  logic [DATA_W-1:0] stage_r;
  logic [DATA_W-1:0] buf_data_r;
  logic              mem_req_r;
  logic              buf_load_r;
  logic              buf_en_r;
  logic              underrun_r;
  logic              ack_take_s;
  logic [ADDR_W-1:0] addr_s;

  // An ack only counts against a live request and never alongside frame_start.
  assign ack_take_s = (state_r == FETCH) & mem_req_r & mem_ack & ~frame_start;

  fetch_addr_ctr #(
    .ADDR_W      (ADDR_W),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_addr_ctr (
    .clk25MHz (clk25MHz),
    .reset    (reset),
    .clr      (frame_start),
    .inc      (ack_take_s),
    .addr     (addr_s)
  );

  // Next-state logic; frame_start restarts the fetch from any state.
  always_comb begin
    state_next_s = state_r;
    if (frame_start) begin
      state_next_s = FETCH;
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s = IDLE;
        end
        FETCH: begin
          if (ack_take_s) begin
            state_next_s = STAGED;
          end else begin
            state_next_s = FETCH;
          end
        end
        STAGED: begin
          if (buf_empty) begin
            state_next_s = LOAD;
          end else begin
            state_next_s = STAGED;
          end
        end
        LOAD: begin
          state_next_s = WAIT_WM;
        end
        WAIT_WM: begin
          if (buf_watermark || buf_empty) begin
            state_next_s = FETCH;
          end else begin
            state_next_s = WAIT_WM;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Memory side: request is dropped for a cycle on frame_start so the
  // address never changes underneath a raised request.
  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      mem_req_r <= 1'b0;
      stage_r   <= {DATA_W{1'b0}};
    end else begin
      mem_req_r <= (state_next_s == FETCH) & ~frame_start;
      if (frame_start) begin
        stage_r <= {DATA_W{1'b0}};
      end else if (ack_take_s) begin
        stage_r <= mem_data;
      end else begin
        stage_r <= stage_r;
      end
    end
  end

  // Buffer side: one-cycle load pulse with the staged word, delayed shift enable.
  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      buf_load_r <= 1'b0;
      buf_data_r <= {DATA_W{1'b0}};
      buf_en_r   <= 1'b0;
    end else begin
      buf_load_r <= (state_next_s == LOAD);
      buf_en_r   <= active;
      if (state_next_s == LOAD) begin
        buf_data_r <= stage_r;
      end else begin
        buf_data_r <= buf_data_r;
      end
    end
  end

  // Sticky underrun; survives frame_start, cleared only by reset.
  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      underrun_r <= 1'b0;
    end else if (buf_en_r && buf_empty && !underrun_exempt(state_r)) begin
      underrun_r <= 1'b1;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  assign mem_req  = mem_req_r;
  assign mem_addr = addr_s;
  assign buf_data = buf_data_r;
  // A restart in the load cycle suppresses the pulse along with the stage.
  assign buf_load = buf_load_r & ~frame_start;
  assign buf_en   = buf_en_r;
  assign underrun = underrun_r;

endmodule
